// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage latch with valid/ready handshakes,
// NOP-bubble insertion on flush/idle and a saturating flush-drop counter.
module pipe_stage_skid #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned CNT_W      = 8,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, pop;
  logic [1:0]        drop_amt;
  logic [CNT_W:0]    drop_sum;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign occupancy = (state == FULL) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) state_nx = ONE;
        ONE: begin
          if (accept && !pop)      state_nx = FULL;
          else if (!accept && pop) state_nx = EMPTY;
        end
        FULL:  if (pop) state_nx = ONE;
        default: state_nx = EMPTY;
      endcase
    end
  end

  // Entries lost to a flush: everything held, less a head that completes
  // its pop this cycle, plus a same-cycle accept.
  always_comb begin
    drop_amt = occupancy;
    if (pop)    drop_amt = drop_amt - 2'd1;
    if (accept) drop_amt = drop_amt + 2'd1;
    drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_amt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      drop_cnt  <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != FULL);
      if (flush) begin
        drop_cnt  <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        main_ctrl <= '0;
        skid_ctrl <= '0;
        if (CLEAR_DATA) begin
          main_data <= '0;
          skid_data <= '0;
        end
      end else begin
        unique case (state)
          EMPTY: begin
            if (accept) begin
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end
          end
          ONE: begin
            if (accept && pop) begin
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end else if (accept) begin
              skid_ctrl <= in_ctrl;
              skid_data <= in_data;
            end else if (pop) begin
              main_ctrl <= '0;
              if (CLEAR_DATA) main_data <= '0;
            end
          end
          FULL: begin
            if (pop) begin
              main_ctrl <= skid_ctrl;
              main_data <= skid_data;
              skid_ctrl <= '0;
              if (CLEAR_DATA) skid_data <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
